// File: rtl/cache_ctrl_2way_if.sv
// Processor/datapath/memory handshake bundle for the 2-way cache controller.
interface cache_ctrl_2way_if;
  logic        proc_read;
  logic        proc_write;
  logic [29:0] proc_addr;
  logic [1:0]  hit_way;
  logic [1:0]  valid_way;
  logic [1:0]  dirty_way;
  logic        mem_ready;
  logic        proc_stall;
  logic        mem_read;
  logic        mem_write;
  logic        addr_sel;
  logic        way_sel;
  logic [1:0]  way_write;
  logic        input_src;
  logic        valid_next;
  logic        dirty_next;

  modport master (
    output proc_read, proc_write, proc_addr, hit_way, valid_way, dirty_way, mem_ready,
    input  proc_stall, mem_read, mem_write, addr_sel, way_sel, way_write,
           input_src, valid_next, dirty_next
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, hit_way, valid_way, dirty_way, mem_ready,
    output proc_stall, mem_read, mem_write, addr_sel, way_sel, way_write,
           input_src, valid_next, dirty_next
  );
endinterface

// File: rtl/cache_ctrl_2way.sv
// Control FSM for a 2-way set-associative write-back/write-allocate cache:
// compare, dirty-victim write-back and refill, with one LRU bit per index.
module cache_ctrl_2way #(
  parameter int LINE_NUM    = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic             clk,
  input  logic             proc_reset,
  cache_ctrl_2way_if.slave bus
);
  typedef enum logic [1:0] {CMP, WB, ALLOC} state_t;

  state_t                 state, state_nx;
  logic [LINE_NUM-1:0]    lru;
  logic                   victim, victim_nx;
  logic                   lru_we, lru_val;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   req, hit, hit_w, miss_victim;

  logic       stall, mem_rd, mem_wr, addr_s, way_s, in_src, v_nx, d_nx;
  logic [1:0] way_wr;

  assign idx = bus.proc_addr[INDEX_WIDTH+1:2];
  assign req = bus.proc_read | bus.proc_write;
  assign hit = |bus.hit_way;
  // hit_way is one-hot on a legal hit; way0 takes priority otherwise
  assign hit_w = ~bus.hit_way[0];
  assign miss_victim = ~bus.valid_way[0] ? 1'b0 :
                       ~bus.valid_way[1] ? 1'b1 : lru[idx];

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state  <= CMP;
      lru    <= '0;
      victim <= 1'b0;
    end else begin
      state  <= state_nx;
      victim <= victim_nx;
      if (lru_we) lru[idx] <= lru_val;
    end
  end

  always_comb begin
    state_nx  = state;
    victim_nx = victim;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    stall     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_s    = 1'b0;
    way_s     = 1'b0;
    way_wr    = 2'b00;
    in_src    = 1'b0;
    v_nx      = 1'b0;
    d_nx      = 1'b0;
    case (state)
      CMP: if (req) begin
        if (hit) begin
          way_s   = hit_w;
          lru_we  = 1'b1;
          lru_val = ~hit_w;
          if (bus.proc_write) begin
            way_wr = hit_w ? 2'b10 : 2'b01;
            v_nx   = 1'b1;
            d_nx   = 1'b1;
          end
        end else begin
          stall     = 1'b1;
          victim_nx = miss_victim;
          state_nx  = (bus.valid_way[miss_victim] && bus.dirty_way[miss_victim]) ? WB : ALLOC;
        end
      end
      WB: begin
        stall  = 1'b1;
        mem_wr = 1'b1;
        addr_s = 1'b1;
        way_s  = victim;
        if (bus.mem_ready) state_nx = ALLOC;
      end
      ALLOC: begin
        stall  = 1'b1;
        mem_rd = 1'b1;
        // refill lands in the victim; the retried request then hits in CMP
        if (bus.mem_ready) begin
          way_wr   = victim ? 2'b10 : 2'b01;
          in_src   = 1'b1;
          v_nx     = 1'b1;
          state_nx = CMP;
        end
      end
      default: state_nx = CMP;
    endcase
  end

  assign bus.proc_stall = stall;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_write  = mem_wr;
  assign bus.addr_sel   = addr_s;
  assign bus.way_sel    = way_s;
  assign bus.way_write  = way_wr;
  assign bus.input_src  = in_src;
  assign bus.valid_next = v_nx;
  assign bus.dirty_next = d_nx;
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed vector table plus randomized run against a queue-based model of
// outstanding memory operations.
module tb_cache_ctrl_2way;
  logic clk = 1'b0;
  logic rst, rd, wr, rdy;
  logic [29:0] addr;
  logic [1:0] hit, valid, dirty;

  cache_ctrl_2way_if bus ();
  cache_ctrl_2way #(.LINE_NUM(8), .INDEX_WIDTH(3)) dut (
    .clk(clk), .proc_reset(rst), .bus(bus.slave)
  );

  assign bus.proc_read  = rd;
  assign bus.proc_write = wr;
  assign bus.proc_addr  = addr;
  assign bus.hit_way    = hit;
  assign bus.valid_way  = valid;
  assign bus.dirty_way  = dirty;
  assign bus.mem_ready  = rdy;

  always #5 clk = ~clk;

  localparam int OP_WB = 1, OP_RD = 2;
  int q[$];
  bit m_lru[8];
  bit m_victim;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    string       name;
    logic        rst, rd, wr;
    logic [29:0] addr;
    logic [1:0]  hit, valid, dirty;
    logic        rdy;
    logic [9:0]  exp;
    logic        chk;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [9:0] pk(logic s, logic mr, logic mw, logic as, logic ws,
                                    logic [1:0] ww, logic is, logic vn, logic dn);
    return {s, mr, mw, as, ws, ww, is, vn, dn};
  endfunction

  function automatic void add(string n, logic r, logic prd, logic pwr, logic [29:0] a,
                              logic [1:0] h, logic [1:0] v, logic [1:0] d, logic rr,
                              logic [9:0] e, logic c);
    vec_t x;
    x.name = n; x.rst = r; x.rd = prd; x.wr = pwr; x.addr = a;
    x.hit = h; x.valid = v; x.dirty = d; x.rdy = rr; x.exp = e; x.chk = c;
    tbl.push_back(x);
  endfunction

  // expected outputs from the pending-operation queue; bit 10 = way_sel is defined
  function automatic logic [10:0] model_exp();
    logic [9:0] e;
    logic       c;
    e = '0; c = 1'b1;
    if (q.size() != 0) begin
      if (q[0] == OP_WB) e = pk(1, 0, 1, 1, m_victim, 2'b00, 0, 0, 0);
      else begin
        c = 1'b0;
        if (rdy) e = pk(1, 1, 0, 0, 0, m_victim ? 2'b10 : 2'b01, 1, 1, 0);
        else     e = pk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
      end
    end else if (rd || wr) begin
      if (hit != 2'b00) begin
        if (wr) e = pk(0, 0, 0, 0, !hit[0], hit[0] ? 2'b01 : 2'b10, 0, 1, 1);
        else    e = pk(0, 0, 0, 0, !hit[0], 2'b00, 0, 0, 0);
      end else begin
        e = pk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        c = 1'b0;
      end
    end
    return {c, e};
  endfunction

  task automatic model_clk();
    int  i;
    bit  v;
    i = int'(addr[4:2]);
    if (rst) begin
      q.delete();
      foreach (m_lru[k]) m_lru[k] = 1'b0;
      m_victim = 1'b0;
    end else if (q.size() != 0) begin
      if (rdy) void'(q.pop_front());
    end else if (rd || wr) begin
      if (hit != 2'b00) m_lru[i] = hit[0];
      else begin
        v = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : m_lru[i];
        m_victim = v;
        if (valid[v] && dirty[v]) q.push_back(OP_WB);
        q.push_back(OP_RD);
      end
    end
  endtask

  task automatic check(string name, logic [9:0] exp, logic chk);
    logic [9:0] act;
    act = {bus.proc_stall, bus.mem_read, bus.mem_write, bus.addr_sel, bus.way_sel & chk,
           bus.way_write, bus.input_src, bus.valid_next, bus.dirty_next};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (stall,rd,wr,asel,wsel,ww,src,vn,dn)",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  initial begin
    logic [10:0] me;
    bit retry, fill;
    rst = 1; rd = 0; wr = 0; addr = '0; hit = 0; valid = 0; dirty = 0; rdy = 0;
    #1; tick(); tick();

    add("rst_idle",  1, 0, 0, 0,     0, 0, 0, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t1_idle",   0, 0, 0, 0,     0, 0, 0, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t1_miss",   0, 1, 0, 'h10,  0, 0, 0, 0, pk(1,0,0,0,0,0,0,0,0), 0);
    add("t1_alloc0", 0, 1, 0, 'h10,  0, 0, 0, 0, pk(1,1,0,0,0,0,0,0,0), 0);
    add("t1_alloc1", 0, 1, 0, 'h10,  0, 0, 0, 0, pk(1,1,0,0,0,0,0,0,0), 0);
    add("t1_fill",   0, 1, 0, 'h10,  0, 0, 0, 1, pk(1,1,0,0,0,2'b01,1,1,0), 0);
    add("t1_hit",    0, 1, 0, 'h10,  1, 1, 0, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t2_wrhit",  0, 0, 1, 'h10,  2, 3, 0, 0, pk(0,0,0,0,1,2'b10,0,1,1), 1);
    add("t3_prep",   0, 1, 0, 'h10,  1, 3, 2, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t3_miss",   0, 1, 0, 'h10,  0, 3, 2, 0, pk(1,0,0,0,0,0,0,0,0), 0);
    add("t3_wb0",    0, 1, 0, 'h10,  0, 3, 2, 0, pk(1,0,1,1,1,0,0,0,0), 1);
    add("t3_wb1",    0, 1, 0, 'h10,  0, 3, 2, 1, pk(1,0,1,1,1,0,0,0,0), 1);
    add("t3_alloc",  0, 1, 0, 'h10,  0, 3, 2, 0, pk(1,1,0,0,0,0,0,0,0), 0);
    add("t3_fill",   0, 1, 0, 'h10,  0, 3, 2, 1, pk(1,1,0,0,0,2'b10,1,1,0), 0);
    add("t3_hit",    0, 1, 0, 'h10,  2, 3, 0, 0, pk(0,0,0,0,1,0,0,0,0), 1);
    add("t4_hit0",   0, 1, 0, 'h8,   1, 3, 1, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t4_miss",   0, 1, 0, 'h8,   0, 3, 1, 0, pk(1,0,0,0,0,0,0,0,0), 0);
    add("t4_fill",   0, 1, 0, 'h8,   0, 3, 1, 1, pk(1,1,0,0,0,2'b10,1,1,0), 0);
    add("t4_hit",    0, 1, 0, 'h8,   2, 3, 1, 0, pk(0,0,0,0,1,0,0,0,0), 1);
    add("t5_prep",   0, 1, 0, 'h14,  1, 3, 3, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t5_miss",   0, 1, 0, 'h10,  0, 3, 3, 0, pk(1,0,0,0,0,0,0,0,0), 0);
    add("t5_wb",     0, 1, 0, 'h10,  0, 3, 3, 0, pk(1,0,1,1,0,0,0,0,0), 1);
    add("t5_rst",    1, 0, 0, 'h10,  0, 3, 3, 0, pk(1,0,1,1,0,0,0,0,0), 1);
    add("t5_idle",   0, 0, 0, 'h10,  0, 3, 3, 0, pk(0,0,0,0,0,0,0,0,0), 1);
    add("t5_lrumiss",0, 1, 0, 'h14,  0, 3, 3, 0, pk(1,0,0,0,0,0,0,0,0), 0);
    add("t5_lruwb",  0, 1, 0, 'h14,  0, 3, 3, 0, pk(1,0,1,1,0,0,0,0,0), 1);
    add("t5_rst2",   1, 0, 0, 'h14,  0, 3, 3, 0, pk(1,0,1,1,0,0,0,0,0), 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr;
      hit = tbl[i].hit; valid = tbl[i].valid; dirty = tbl[i].dirty; rdy = tbl[i].rdy;
      @(negedge clk);
      check(tbl[i].name, tbl[i].exp, tbl[i].chk);
      tick();
    end

    rst = 0; rd = 0; wr = 0;
    for (int i = 0; i < 10; i++) begin
      rdy = (i % 3 == 0);
      @(negedge clk);
      check("t6_idle", pk(0,0,0,0,0,0,0,0,0), 1);
      tick();
    end

    retry = 0;
    for (int c = 0; c < 2000; c++) begin
      if (q.size() == 0) begin
        if (retry) begin
          rst = 0;
          hit = m_victim ? 2'b10 : 2'b01;
          valid = valid | hit;
          retry = 0;
        end else begin
          rst   = ($urandom_range(0, 99) == 0);
          rd    = $urandom_range(0, 1) == 1;
          wr    = $urandom_range(0, 1) == 1;
          addr  = 30'($urandom);
          valid = 2'($urandom);
          dirty = 2'($urandom);
          hit   = 2'b00;
          if (valid != 2'b00 && $urandom_range(0, 1) == 1)
            hit = !valid[0] ? 2'b10 : (valid[1] && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        end
      end else begin
        rst = ($urandom_range(0, 199) == 0);
      end
      rdy = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      me = model_exp();
      check("rand", me[9:0], me[10]);
      fill = !rst && q.size() != 0 && q[0] == OP_RD && rdy;
      tick();
      retry = fill;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
